// File: rtl/etapa_ex_pkg.sv
// Shared definitions for the ProcesadorJOF32 execute stage: widths, ALU encodings,
// shift direction and the MEM/WB control bundle.
package etapa_ex_pkg;

    localparam int unsigned W       = 32;
    localparam int unsigned RW      = 4;
    localparam int unsigned OPW     = 5;
    localparam int unsigned IMM_BIT = 4;
    localparam int unsigned SH_W    = $clog2(W);
    localparam int unsigned CNT_W   = $clog2(W + 1);

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_SHIFT = 2'b10,
        ALU_MUL   = 2'b11
    } alu_sel_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ex_state_e;

    typedef struct packed {
        logic mem_wr;
        logic reg_wr;
        logic sel_wb;
        logic sel_ld;
    } mem_wb_ctrl_t;

endpackage

// File: rtl/etapa_ex_if.sv
// ID/EX -> EX -> EX/MEM signal bundle; master is the upstream/downstream side,
// slave is the execute stage.
interface etapa_ex_if;
    import etapa_ex_pkg::*;

    logic               valid_in;
    logic [OPW-1:0]     opcode_in;
    logic [W-1:0]       a_in;
    logic [W-1:0]       b_in;
    logic [W-1:0]       shamt_in;
    logic [W-1:0]       inm_in;
    logic [RW-1:0]      rd_in;
    alu_sel_e           alu_sel_in;
    dir_e               dir_sl_in;
    logic               mem_wr_in;
    logic               reg_wr_in;
    logic               sel_wb_in;
    logic               sel_ld_in;

    logic               stall;
    logic               valid_out;
    logic [W-1:0]       result_out;
    logic [W-1:0]       store_out;
    logic               zero_out;
    logic [RW-1:0]      rd_out;
    logic               mem_wr_out;
    logic               reg_wr_out;
    logic               sel_wb_out;
    logic               sel_ld_out;

    modport master (
        output valid_in, opcode_in, a_in, b_in, shamt_in, inm_in, rd_in,
               alu_sel_in, dir_sl_in, mem_wr_in, reg_wr_in, sel_wb_in, sel_ld_in,
        input  stall, valid_out, result_out, store_out, zero_out, rd_out,
               mem_wr_out, reg_wr_out, sel_wb_out, sel_ld_out
    );

    modport slave (
        input  valid_in, opcode_in, a_in, b_in, shamt_in, inm_in, rd_in,
               alu_sel_in, dir_sl_in, mem_wr_in, reg_wr_in, sel_wb_in, sel_ld_in,
        output stall, valid_out, result_out, store_out, zero_out, rd_out,
               mem_wr_out, reg_wr_out, sel_wb_out, sel_ld_out
    );

endinterface

// File: rtl/etapa_ex_iter_unit.sv
// Iterative SHIFT / MUL engine: one shift bit or one multiplier bit per cycle.
// result_c is the value the current iteration produces; done_c flags the last one.
module etapa_ex_iter_unit
    import etapa_ex_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  alu_sel_e         op,
    input  dir_e             dir,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [CNT_W-1:0] n,
    output logic             busy,
    output logic             done_c,
    output logic [W-1:0]     result_c
);

    logic [W-1:0]     acc;
    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic [CNT_W-1:0] count;
    logic             is_mul;
    dir_e             dir_q;
    logic [W-1:0]     acc_nxt;

    // Shift-add for MUL, single-bit logical shift otherwise
    always_comb begin
        acc_nxt = acc;
        if (is_mul) begin
            acc_nxt = acc + (mplier[0] ? mcand : '0);
        end else if (dir_q == DIR_RIGHT) begin
            acc_nxt = acc >> 1;
        end else begin
            acc_nxt = acc << 1;
        end
        done_c   = busy && (count == CNT_W'(1));
        result_c = acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            is_mul <= 1'b0;
            dir_q  <= DIR_LEFT;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= (op == ALU_MUL) ? '0 : a;
            mcand  <= a;
            mplier <= b;
            count  <= n;
            is_mul <= (op == ALU_MUL);
            dir_q  <= dir;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/etapa_ex.sv
// Execute stage: operand mux, single-cycle ADD/SUB, multi-cycle SHIFT/MUL via the
// iterator, and the EX/MEM output register. Stalls upstream while iterating.
module etapa_ex
    import etapa_ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    etapa_ex_if.slave   bus
);

    ex_state_e        state, state_nxt;
    logic [W-1:0]     opb_c;
    logic [W-1:0]     fast_res_c;
    logic [W-1:0]     iter_res_c;
    logic [CNT_W-1:0] iter_n_c;
    logic             slow_c;
    logic             stall_c;
    logic             iter_start_c;
    logic             iter_done_c;
    logic             iter_busy;
    logic             fast_load_c;
    logic             slow_load_c;
    mem_wb_ctrl_t     ctrl_in_c;
    mem_wb_ctrl_t     cap_ctrl;
    logic [W-1:0]     cap_store;
    logic [RW-1:0]    cap_rd;
    logic             unused_c;

    assign unused_c = ^{bus.shamt_in[W-1:SH_W], bus.opcode_in, iter_busy};

    // Operand selection and single-cycle datapath
    always_comb begin
        opb_c     = bus.opcode_in[IMM_BIT] ? bus.inm_in : bus.b_in;
        ctrl_in_c = '{mem_wr: bus.mem_wr_in, reg_wr: bus.reg_wr_in,
                      sel_wb: bus.sel_wb_in, sel_ld: bus.sel_ld_in};
        slow_c    = (bus.alu_sel_in == ALU_MUL) ||
                    ((bus.alu_sel_in == ALU_SHIFT) && (bus.shamt_in[SH_W-1:0] != '0));
        iter_n_c  = (bus.alu_sel_in == ALU_MUL) ? CNT_W'(W)
                                                 : CNT_W'(bus.shamt_in[SH_W-1:0]);
        case (bus.alu_sel_in)
            ALU_ADD: fast_res_c = bus.a_in + opb_c;
            ALU_SUB: fast_res_c = bus.a_in - opb_c;
            default: fast_res_c = bus.a_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stall drops in the final iteration cycle so ID/EX can advance in lockstep
    always_comb begin
        state_nxt    = state;
        stall_c      = 1'b0;
        iter_start_c = 1'b0;
        fast_load_c  = 1'b0;
        slow_load_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.valid_in && !rst) begin
                    if (slow_c) begin
                        iter_start_c = 1'b1;
                        stall_c      = 1'b1;
                        state_nxt    = ST_BUSY;
                    end else begin
                        fast_load_c  = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (iter_done_c) begin
                    slow_load_c = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    stall_c     = 1'b1;
                end
            end
        endcase
    end

    assign bus.stall = stall_c;

    etapa_ex_iter_unit u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (iter_start_c),
        .op       (bus.alu_sel_in),
        .dir      (bus.dir_sl_in),
        .a        (bus.a_in),
        .b        (opb_c),
        .n        (iter_n_c),
        .busy     (iter_busy),
        .done_c   (iter_done_c),
        .result_c (iter_res_c)
    );

    // Side data for multi-cycle ops is captured at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_ctrl  <= '0;
            cap_store <= '0;
            cap_rd    <= '0;
        end else if (iter_start_c) begin
            cap_ctrl  <= ctrl_in_c;
            cap_store <= bus.b_in;
            cap_rd    <= bus.rd_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_out  <= 1'b0;
            bus.result_out <= '0;
            bus.store_out  <= '0;
            bus.zero_out   <= 1'b1;
            bus.rd_out     <= '0;
            bus.mem_wr_out <= 1'b0;
            bus.reg_wr_out <= 1'b0;
            bus.sel_wb_out <= 1'b0;
            bus.sel_ld_out <= 1'b0;
        end else if (fast_load_c) begin
            bus.valid_out  <= 1'b1;
            bus.result_out <= fast_res_c;
            bus.zero_out   <= (fast_res_c == '0);
            bus.store_out  <= bus.b_in;
            bus.rd_out     <= bus.rd_in;
            bus.mem_wr_out <= ctrl_in_c.mem_wr;
            bus.reg_wr_out <= ctrl_in_c.reg_wr;
            bus.sel_wb_out <= ctrl_in_c.sel_wb;
            bus.sel_ld_out <= ctrl_in_c.sel_ld;
        end else if (slow_load_c) begin
            bus.valid_out  <= 1'b1;
            bus.result_out <= iter_res_c;
            bus.zero_out   <= (iter_res_c == '0);
            bus.store_out  <= cap_store;
            bus.rd_out     <= cap_rd;
            bus.mem_wr_out <= cap_ctrl.mem_wr;
            bus.reg_wr_out <= cap_ctrl.reg_wr;
            bus.sel_wb_out <= cap_ctrl.sel_wb;
            bus.sel_ld_out <= cap_ctrl.sel_ld;
        end else begin
            bus.valid_out  <= 1'b0;
            bus.mem_wr_out <= 1'b0;
            bus.reg_wr_out <= 1'b0;
        end
    end

endmodule
